// File: rtl/time_pkg.sv
// Shared definitions for the clock display: segment patterns, digit slots and the frame snapshot.
package time_pkg;

  // Active-high segment patterns, bit order {g,f,e,d,c,b,a}.
  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_DASH  = 7'h40;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  typedef logic [1:0] dig_idx_t;

  localparam dig_idx_t DIG_ML = 2'd0;
  localparam dig_idx_t DIG_MH = 2'd1;
  localparam dig_idx_t DIG_HL = 2'd2;
  localparam dig_idx_t DIG_HH = 2'd3;

  typedef struct packed {
    logic [3:0] hh;
    logic [3:0] hl;
    logic [3:0] mh;
    logic [3:0] ml;
    logic       mode;
  } time_snap_t;

endpackage

// File: rtl/bcd_to_seg7.sv
// BCD digit to active-high 7-segment pattern; non-BCD codes render as a dash.
module bcd_to_seg7
  import time_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_DASH;
    case (bcd_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/time_display_scan.sv
// Four-digit multiplexed 7-segment driver for HH:MM with per-frame snapshot,
// 12-hour leading-zero blanking and a blinking colon on the hours-units dp.
module time_display_scan
  import time_pkg::*;
#(
  parameter int unsigned SCAN_DIV       = 50000,
  parameter int unsigned BLINK_FRAMES   = 250,
  parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] HL,
  input  logic [3:0] HH,
  input  logic [3:0] ML,
  input  logic [3:0] MH,
  input  logic       mode,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int unsigned PrescW = $clog2(SCAN_DIV);
  localparam int unsigned FrameW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [6:0]  SegOff = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic        DpOff  = SEG_ACTIVE_LOW;

  logic [PrescW-1:0] presc_q, presc_d;
  dig_idx_t          idx_q, idx_d;
  time_snap_t        snap_q, snap_d;
  logic [FrameW-1:0] frame_q, frame_d;
  logic              colon_q, colon_d;
  logic              run_q, run_d;
  logic [3:0]        an_q, an_d;
  logic [6:0]        seg_q, seg_d;
  logic              dp_q, dp_d;

  logic              tick, wrap;
  logic [3:0]        digit;
  logic [6:0]        digit_seg, seg_raw;
  logic              dp_raw;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc_q <= '0;
      idx_q   <= DIG_HH;
      snap_q  <= '0;
      frame_q <= '0;
      colon_q <= 1'b0;
      run_q   <= 1'b0;
      an_q    <= 4'b1111;
      seg_q   <= SegOff;
      dp_q    <= DpOff;
    end else begin
      presc_q <= presc_d;
      idx_q   <= idx_d;
      snap_q  <= snap_d;
      frame_q <= frame_d;
      colon_q <= colon_d;
      run_q   <= run_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
    end
  end

  always_comb begin
    tick    = (presc_q == PrescW'(SCAN_DIV - 1));
    presc_d = tick ? '0 : presc_q + 1'b1;
    idx_d   = tick ? dig_idx_t'(idx_q + 2'd1) : idx_q;
    wrap    = tick && (idx_q == DIG_HH);
    run_d   = run_q | tick;

    snap_d = snap_q;
    if (wrap) begin
      snap_d.hh   = HH;
      snap_d.hl   = HL;
      snap_d.mh   = MH;
      snap_d.ml   = ML;
      snap_d.mode = mode;
    end

    // The wrap out of reset opens frame 0 but closes no frame, so it is not counted.
    frame_d = frame_q;
    colon_d = colon_q;
    if (wrap && run_q) begin
      if (frame_q == FrameW'(BLINK_FRAMES - 1)) begin
        frame_d = '0;
        colon_d = ~colon_q;
      end else begin
        frame_d = frame_q + 1'b1;
      end
    end
  end

  // Outputs are decoded from the next index and next snapshot so that the first
  // slot of a frame already shows the freshly captured digits.
  always_comb begin
    digit = '0;
    unique case (idx_d)
      DIG_ML: digit = snap_d.ml;
      DIG_MH: digit = snap_d.mh;
      DIG_HL: digit = snap_d.hl;
      DIG_HH: digit = snap_d.hh;
    endcase

    if ((idx_d == DIG_HH) && !snap_d.mode && (snap_d.hh == 4'd0)) begin
      seg_raw = SEG_BLANK;
    end else begin
      seg_raw = digit_seg;
    end
    dp_raw = (idx_d == DIG_HL) && colon_d;

    an_d  = an_q;
    seg_d = seg_q;
    dp_d  = dp_q;
    if (tick) begin
      an_d  = ~(4'b0001 << idx_d);
      seg_d = seg_raw ^ {7{SEG_ACTIVE_LOW}};
      dp_d  = dp_raw ^ SEG_ACTIVE_LOW;
    end
  end

  bcd_to_seg7 u_dec (
    .bcd_i (digit),
    .seg_o (digit_seg)
  );

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule
